// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: drives PC strobes, issues ROM requests,
// retries on timeout and hands fetched instructions to the consumer.
module fetch_ctrl #(
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] pc_in,
    output logic             pc_inc,
    output logic             pc_jump,
    output logic             pc_reset,
    output logic [WIDTH-1:0] pc_data,
    output logic             rom_req,
    output logic [WIDTH-1:0] rom_addr,
    input  logic             rom_ack,
    input  logic [WIDTH-1:0] rom_data,
    output logic             instr_valid,
    output logic [WIDTH-1:0] instr,
    input  logic             instr_ready,
    input  logic             br_valid,
    input  logic [WIDTH-1:0] br_target,
    input  logic             halt,
    output logic             halted,
    output logic             err_timeout,
    output logic [WIDTH-1:0] retired
);

    localparam logic [2:0] S_RST   = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_HOLD  = 3'd2;
    localparam logic [2:0] S_ADV   = 3'd3;
    localparam logic [2:0] S_HALT  = 3'd4;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    logic [2:0]       state_q, state_d;
    logic             pc_inc_q, pc_inc_d;
    logic             pc_jump_q, pc_jump_d;
    logic             pc_reset_q, pc_reset_d;
    logic [WIDTH-1:0] pc_data_q, pc_data_d;
    logic             rom_req_q, rom_req_d;
    logic             instr_valid_q, instr_valid_d;
    logic [WIDTH-1:0] instr_q, instr_d;
    logic             halted_q, halted_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] retired_q, retired_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             enter;

    always_comb begin
        state_d       = state_q;
        pc_inc_d      = 1'b0;
        pc_jump_d     = 1'b0;
        pc_reset_d    = 1'b0;
        pc_data_d     = pc_data_q;
        rom_req_d     = rom_req_q;
        instr_valid_d = instr_valid_q;
        instr_d       = instr_q;
        halted_d      = halted_q;
        err_d         = err_q;
        retired_d     = retired_q;
        cnt_d         = cnt_q;
        enter         = 1'b0;

        unique case (state_q)
            S_RST: begin
                if (pc_reset_q) enter = 1'b1;
                else            pc_reset_d = 1'b1;
            end
            // FETCH with rom_req low is the one-cycle retry gap
            S_FETCH: begin
                if (!rom_req_q) begin
                    enter = 1'b1;
                end else if (rom_ack) begin
                    instr_d       = rom_data;
                    instr_valid_d = 1'b1;
                    rom_req_d     = 1'b0;
                    cnt_d         = 8'd0;
                    state_d       = S_HOLD;
                end else if (cnt_q == TO_LAST) begin
                    err_d     = 1'b1;
                    rom_req_d = 1'b0;
                    cnt_d     = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_HOLD: begin
                if (instr_ready) begin
                    instr_valid_d = 1'b0;
                    retired_d     = retired_q + 1'b1;
                    pc_jump_d     = br_valid;
                    pc_inc_d      = !br_valid;
                    if (br_valid) pc_data_d = br_target;
                    state_d = S_ADV;
                end
            end
            S_ADV: begin
                enter = 1'b1;
            end
            S_HALT: begin
                if (!halt) enter = 1'b1;
            end
            default: begin
                state_d = S_RST;
            end
        endcase

        if (enter) begin
            if (halt) begin
                state_d  = S_HALT;
                halted_d = 1'b1;
            end else begin
                state_d   = S_FETCH;
                halted_d  = 1'b0;
                rom_req_d = 1'b1;
                cnt_d     = 8'd0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_RST;
            pc_inc_q      <= 1'b0;
            pc_jump_q     <= 1'b0;
            pc_reset_q    <= 1'b0;
            pc_data_q     <= '0;
            rom_req_q     <= 1'b0;
            instr_valid_q <= 1'b0;
            instr_q       <= '0;
            halted_q      <= 1'b0;
            err_q         <= 1'b0;
            retired_q     <= '0;
            cnt_q         <= 8'd0;
        end else begin
            state_q       <= state_d;
            pc_inc_q      <= pc_inc_d;
            pc_jump_q     <= pc_jump_d;
            pc_reset_q    <= pc_reset_d;
            pc_data_q     <= pc_data_d;
            rom_req_q     <= rom_req_d;
            instr_valid_q <= instr_valid_d;
            instr_q       <= instr_d;
            halted_q      <= halted_d;
            err_q         <= err_d;
            retired_q     <= retired_d;
            cnt_q         <= cnt_d;
        end
    end

    // pc_in is only updated by our own strobes, so it is stable while requesting
    assign rom_addr    = rom_req_q ? pc_in : '0;
    assign rom_req     = rom_req_q;
    assign pc_inc      = pc_inc_q;
    assign pc_jump     = pc_jump_q;
    assign pc_reset    = pc_reset_q;
    assign pc_data     = pc_data_q;
    assign instr_valid = instr_valid_q;
    assign instr       = instr_q;
    assign halted      = halted_q;
    assign err_timeout = err_q;
    assign retired     = retired_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a PC register model and an
// instruction scoreboard filled at ROM ack and drained at accept.
module tb_fetch_ctrl;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [W-1:0] tb_pc = 16'h0007;
    logic         pc_inc, pc_jump, pc_reset;
    logic [W-1:0] pc_data;
    logic         rom_req;
    logic [W-1:0] rom_addr;
    logic         rom_ack = 1'b0;
    logic [W-1:0] rom_data = '0;
    logic         instr_valid;
    logic [W-1:0] instr;
    logic         instr_ready = 1'b0;
    logic         br_valid = 1'b0;
    logic [W-1:0] br_target = '0;
    logic         halt = 1'b0;
    logic         halted, err_timeout;
    logic [W-1:0] retired;

    int checks = 0;
    int failures = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_pc = '0;
    logic [W-1:0] exp_ret = '0;
    logic [W-1:0] exp_pcd = '0;
    logic [W-1:0] front;

    fetch_ctrl #(.WIDTH(W), .TIMEOUT(15)) dut (
        .clk(clk), .reset(reset), .pc_in(tb_pc),
        .pc_inc(pc_inc), .pc_jump(pc_jump), .pc_reset(pc_reset),
        .pc_data(pc_data), .rom_req(rom_req), .rom_addr(rom_addr),
        .rom_ack(rom_ack), .rom_data(rom_data),
        .instr_valid(instr_valid), .instr(instr),
        .instr_ready(instr_ready), .br_valid(br_valid),
        .br_target(br_target), .halt(halt), .halted(halted),
        .err_timeout(err_timeout), .retired(retired)
    );

    always #5 clk = ~clk;

    // Program counter the controller steers through its strobes
    always @(posedge clk) begin
        if (pc_reset)     tb_pc <= '0;
        else if (pc_inc)  tb_pc <= tb_pc + 16'd1;
        else if (pc_jump) tb_pc <= pc_data;
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [W-1:0] obs,
                        input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_check(input string tag);
        chk1({tag, "_req"}, rom_req, 1'b1);
        chkw({tag, "_addr"}, rom_addr, exp_pc);
        chk1({tag, "_inc0"}, pc_inc, 1'b0);
        chk1({tag, "_jmp0"}, pc_jump, 1'b0);
    endtask

    task automatic do_fetch(input int delay, input logic [W-1:0] data);
        start_check("fetch_start");
        for (int i = 0; i < delay; i++) begin
            step();
            chk1("wait_req", rom_req, 1'b1);
            chkw("wait_addr", rom_addr, exp_pc);
            chk1("wait_nvalid", instr_valid, 1'b0);
        end
        rom_ack = 1'b1;
        rom_data = data;
        exp_q.push_back(data);
        step();
        rom_ack = 1'b0;
        rom_data = 16'hDEAD;
        chk1("ack_valid", instr_valid, 1'b1);
        chk1("ack_req_drop", rom_req, 1'b0);
    endtask

    task automatic hold_cycles(input int n);
        instr_ready = 1'b0;
        for (int i = 0; i < n; i++) begin
            br_valid = 1'b1;
            br_target = 16'h0BAD;
            rom_ack = 1'b1;
            rom_data = 16'hFFFF;
            step();
            chk1("hold_valid", instr_valid, 1'b1);
            chkw("hold_instr", instr, exp_q[0]);
            chk1("hold_noreq", rom_req, 1'b0);
        end
        br_valid = 1'b0;
        rom_ack = 1'b0;
    endtask

    task automatic accept(input logic br, input logic [W-1:0] tgt);
        instr_ready = 1'b1;
        br_valid = br;
        br_target = tgt;
        front = exp_q.pop_front();
        chk1("acc_valid", instr_valid, 1'b1);
        chkw("acc_instr", instr, front);
        step();
        instr_ready = 1'b0;
        br_valid = 1'b0;
        exp_ret = exp_ret + 16'd1;
        if (br) begin
            exp_pc = tgt;
            exp_pcd = tgt;
        end else begin
            exp_pc = exp_pc + 16'd1;
        end
        chk1("adv_nvalid", instr_valid, 1'b0);
        chkw("adv_retired", retired, exp_ret);
        chk1("adv_inc", pc_inc, !br);
        chk1("adv_jump", pc_jump, br);
        chk1("adv_rst0", pc_reset, 1'b0);
        chkw("adv_pcdata", pc_data, exp_pcd);
    endtask

    initial begin
        #2;
        chk1("rst_valid", instr_valid, 1'b0);
        chk1("rst_req", rom_req, 1'b0);
        chkw("rst_addr", rom_addr, 16'h0000);
        chkw("rst_retired", retired, 16'h0000);
        chk1("rst_err", err_timeout, 1'b0);
        chk1("rst_halted", halted, 1'b0);
        chk1("rst_pcreset", pc_reset, 1'b0);
        chkw("rst_pcdata", pc_data, 16'h0000);
        reset = 1'b1;
        step();
        chk1("pcreset_pulse", pc_reset, 1'b1);
        chk1("pcreset_noreq", rom_req, 1'b0);
        step();
        chk1("pcreset_end", pc_reset, 1'b0);

        do_fetch(0, 16'hA001);
        accept(1'b1, 16'd5);
        step();
        do_fetch(3, 16'h1234);
        accept(1'b0, 16'h0000);
        step();
        do_fetch(14, 16'hBEEF);
        chk1("ack_wins_err", err_timeout, 1'b0);
        hold_cycles(3);
        accept(1'b0, 16'h0000);
        step();

        start_check("to_start");
        for (int i = 0; i < 14; i++) begin
            step();
            chk1("to_req", rom_req, 1'b1);
            chk1("to_err0", err_timeout, 1'b0);
        end
        step();
        chk1("to_gap_req", rom_req, 1'b0);
        chk1("to_err1", err_timeout, 1'b1);
        step();
        chk1("to_err_sticky", err_timeout, 1'b1);
        do_fetch(0, 16'hC0DE);
        accept(1'b1, 16'd1997);
        halt = 1'b1;
        step();
        chk1("halt_enter", halted, 1'b1);
        chk1("halt_noreq", rom_req, 1'b0);
        chk1("halt_nojump", pc_jump, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk1("halt_hold", halted, 1'b1);
            chk1("halt_hold_noreq", rom_req, 1'b0);
            chk1("halt_noinc", pc_inc, 1'b0);
        end
        halt = 1'b0;
        step();
        chk1("halt_exit", halted, 1'b0);
        do_fetch(1, 16'h5A5A);
        hold_cycles(10);

        #2;
        reset = 1'b0;
        #1;
        chk1("mid_rst_valid", instr_valid, 1'b0);
        chkw("mid_rst_instr", instr, 16'h0000);
        chk1("mid_rst_req", rom_req, 1'b0);
        chkw("mid_rst_retired", retired, 16'h0000);
        chk1("mid_rst_err", err_timeout, 1'b0);
        chkw("mid_rst_pcdata", pc_data, 16'h0000);
        exp_q.delete();
        exp_ret = '0;
        exp_pcd = '0;
        for (int i = 0; i < 2; i++) begin
            instr_ready = 1'b1;
            step();
            chk1("rst_hold_inc", pc_inc, 1'b0);
            chk1("rst_hold_jump", pc_jump, 1'b0);
            chk1("rst_hold_pcr", pc_reset, 1'b0);
        end
        instr_ready = 1'b0;
        reset = 1'b1;
        step();
        chk1("rerst_pulse", pc_reset, 1'b1);
        step();
        exp_pc = '0;
        do_fetch(0, 16'h7777);
        accept(1'b0, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
